// File: rtl/clkdiv_tick.sv
// clkdiv_tick: turns rising edges of a run-time selected divider tap into one-cycle tick
// enables, optionally grouped into step pulses when CLKDIV_TICK_STEP_EN is defined.
module clkdiv_tick #(
    parameter int DIV_W = 32,
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_in,
    input  logic [SEL_W-1:0] sel,
    input  logic [7:0]       step_len,
    input  logic             run,
    input  logic             clr,
    output logic             tick,
    output logic             step,
    output logic [7:0]       tick_cnt,
    output logic [15:0]      step_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             prev_q, prev_d;
    logic             tick_q, tick_d;
    logic             cur_bit;
    logic             new_bit;
    logic             tap_chg;
    logic             rise;
    logic             align;

    assign cur_bit = div_in[sel_q];
    assign new_bit = div_in[sel];
    assign tap_chg = (sel != sel_q);
    assign rise    = cur_bit && !prev_q;

    // A clear or a tap change re-arms, so the next edge only re-aligns the phase.
    always_comb begin
        sel_d   = sel_q;
        prev_d  = cur_bit;
        state_d = state_q;
        tick_d  = 1'b0;
        align   = 1'b0;
        if (tap_chg) begin
            sel_d  = sel;
            prev_d = new_bit;
        end
        if (clr || tap_chg) begin
            state_d = run ? ARM : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run) state_d = ARM;
                end
                ARM: begin
                    if (!run) begin
                        state_d = IDLE;
                    end else if (rise) begin
                        align   = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state_d = IDLE;
                    end else if (rise) begin
                        tick_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            prev_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            prev_q  <= prev_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

`ifdef CLKDIV_TICK_STEP_EN
    logic [7:0]  tick_cnt_q, tick_cnt_d;
    logic [15:0] step_cnt_q, step_cnt_d;
    logic        step_q, step_d;
    logic        match;

    // 8-bit modular compare makes step_len of 0 behave as 256.
    assign match = (tick_cnt_q == (step_len - 8'd1));

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        step_cnt_d = step_cnt_q;
        step_d     = 1'b0;
        if (clr) begin
            tick_cnt_d = '0;
            step_cnt_d = '0;
        end else if (align) begin
            tick_cnt_d = '0;
        end else if (tick_d) begin
            if (match) begin
                step_d     = 1'b1;
                tick_cnt_d = '0;
                step_cnt_d = step_cnt_q + 16'd1;
            end else begin
                tick_cnt_d = tick_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
            step_cnt_q <= '0;
            step_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            step_cnt_q <= step_cnt_d;
            step_q     <= step_d;
        end
    end

    assign step     = step_q;
    assign tick_cnt = tick_cnt_q;
    assign step_cnt = step_cnt_q;
`else
    logic unused_step_inputs;

    assign unused_step_inputs = ^{step_len, align};
    assign step     = 1'b0;
    assign tick_cnt = '0;
    assign step_cnt = '0;
`endif

endmodule
